frame_scheduler: RTL

Top-level sequencer for the acoustic fingerprint pipeline. It runs the power-on wait, arms sample capture, then hands each full 512-sample frame to the window/FFT stage, then feature extraction, then the packet/UART stage, and loops. It sits in acoustic_top between the button conditioning and the datapath blocks. It drives only start/clear strobes and status; it carries no sample data.

---
 rtl/frame_scheduler_if.sv | 16 +
 rtl/frame_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if: start/clear strobes, done handshakes and status between the scheduler and the datapath stages.
interface frame_scheduler_if #(
  parameter int FRAME_W = 16
);
  logic start_pulse, cap_full, fft_done, feat_done, pkt_done;
  logic cap_clear, cap_en, fft_start, feat_start, pkt_start, busy, err, led;
  logic [FRAME_W-1:0] frame_num;
  modport master (
    input  start_pulse, cap_full, fft_done, feat_done, pkt_done,
    output cap_clear, cap_en, fft_start, feat_start, pkt_start, frame_num, busy, err, led
  );
  modport slave (
    output start_pulse, cap_full, fft_done, feat_done, pkt_done,
    input  cap_clear, cap_en, fft_start, feat_start, pkt_start, frame_num, busy, err, led
  );
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler: POR wait, then capture -> FFT -> features -> packet per frame, looping until stopped.
// Define STAGE_TIMEOUT_EN to add a per-stage done watchdog that raises a sticky err and returns to IDLE.
module frame_scheduler #(
  parameter int POR_CYCLES     = 120000,
  parameter int FRAME_W        = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic               clk,
  input logic               btn_reset,
  frame_scheduler_if.master io_bus
);
  typedef enum logic [2:0] {S_POR, S_IDLE, S_CAP, S_FFT, S_FEAT, S_PKT} state_t;
  localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  if (POR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("frame_scheduler: POR_CYCLES and TIMEOUT_CYCLES must be positive");
  end
  state_t             r_state, w_next;
  logic [POR_W-1:0]   r_por_cnt;
  logic [1:0]         r_cap_cnt;
  logic [FRAME_W-1:0] r_frame_num;
  logic r_run, r_stop_req, r_cap_clear, r_cap_en, r_fft_start, r_feat_start, r_pkt_start, r_busy;
  logic w_run, w_stop_req, w_inc, w_stage, w_done, w_timeout;
  assign w_stage = r_state inside {S_FFT, S_FEAT, S_PKT};
  assign w_done  = (r_state == S_FFT)  ? io_bus.fft_done  :
                   (r_state == S_FEAT) ? io_bus.feat_done :
                   (r_state == S_PKT)  ? io_bus.pkt_done  : 1'b0;
`ifdef STAGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  assign w_timeout = w_stage && !w_done && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge btn_reset)
    if (btn_reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (w_next != r_state) ? '0 : r_to_cnt + TO_W'(1);
      r_err    <= r_err | w_timeout;
    end
  assign io_bus.err = r_err;
`else
  assign w_timeout  = 1'b0;
  assign io_bus.err = 1'b0;
`endif
  always_comb begin
    w_next     = r_state;
    w_run      = r_run;
    w_stop_req = r_stop_req | (w_stage & io_bus.start_pulse);
    w_inc      = 1'b0;
    if (w_timeout) begin
      w_next     = S_IDLE;
      w_run      = 1'b0;
      w_stop_req = 1'b0;
    end else
      case (r_state)
        S_POR:  if (r_por_cnt == POR_W'(POR_CYCLES - 1)) w_next = S_IDLE;
        S_IDLE: if (io_bus.start_pulse) begin
          w_next = S_CAP;
          w_run  = 1'b1;
        end
        // cap_full may still be high from the previous frame until the cleared pointer propagates
        S_CAP:  if (io_bus.start_pulse) begin
          w_next = S_IDLE;
          w_run  = 1'b0;
        end else if (io_bus.cap_full && r_cap_cnt == 2'd2) w_next = S_FFT;
        S_FFT:  if (w_done) w_next = S_FEAT;
        S_FEAT: if (w_done) w_next = S_PKT;
        S_PKT:  if (w_done) begin
          w_inc      = 1'b1;
          w_next     = w_stop_req ? S_IDLE : S_CAP;
          w_run      = !w_stop_req;
          w_stop_req = 1'b0;
        end
        default: w_next = S_POR;
      endcase
  end
  always_ff @(posedge clk or posedge btn_reset)
    if (btn_reset) begin
      r_state      <= S_POR;
      r_por_cnt    <= '0;
      r_cap_cnt    <= 2'd0;
      r_frame_num  <= '0;
      r_run        <= 1'b0;
      r_stop_req   <= 1'b0;
      r_cap_clear  <= 1'b0;
      r_cap_en     <= 1'b0;
      r_fft_start  <= 1'b0;
      r_feat_start <= 1'b0;
      r_pkt_start  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_por_cnt    <= (r_state == S_POR) ? r_por_cnt + POR_W'(1) : '0;
      r_cap_cnt    <= (r_state != S_CAP) ? 2'd0 : (r_cap_cnt == 2'd2) ? 2'd2 : r_cap_cnt + 2'd1;
      r_frame_num  <= r_frame_num + FRAME_W'(w_inc);
      r_run        <= w_run;
      r_stop_req   <= w_stop_req;
      r_cap_clear  <= w_next == S_CAP  && r_state != S_CAP;
      r_cap_en     <= w_next == S_CAP  && r_state == S_CAP;
      r_fft_start  <= w_next == S_FFT  && r_state != S_FFT;
      r_feat_start <= w_next == S_FEAT && r_state != S_FEAT;
      r_pkt_start  <= w_next == S_PKT  && r_state != S_PKT;
      r_busy       <= w_next inside {S_FFT, S_FEAT, S_PKT};
    end
  assign io_bus.cap_clear  = r_cap_clear;
  assign io_bus.cap_en     = r_cap_en;
  assign io_bus.fft_start  = r_fft_start;
  assign io_bus.feat_start = r_feat_start;
  assign io_bus.pkt_start  = r_pkt_start;
  assign io_bus.frame_num  = r_frame_num;
  assign io_bus.busy       = r_busy;
  assign io_bus.led        = r_run;
endmodule
